// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed scan controller sharing one seven-segment decoder
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (suppress leading-zero digits above digit 0).
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [3:0]                    seg_in,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start,
  output logic                          pending
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_nx;
  logic                    running;
  logic [CW-1:0]           slot_cnt, cnt_nx;
  logic [IW-1:0]           idx_nx;
  logic [4*NUM_DIGITS-1:0] display, pend_data, disp_nx;
  logic [NUM_DIGITS-1:0]   lead_zero, suppress, anode_nx;
  logic [3:0]              nib_nx;
  logic                    slot_end, frame_end, boundary, run_zero;

  // Registers hold the cycle being presented; the first edge out of reset
  // presents cycle 0 of slot 0 without advancing the counters.
  always_comb begin
    slot_end  = (slot_cnt == CW'(REFRESH_DIV - 1));
    frame_end = slot_end && (digit_idx == IW'(NUM_DIGITS - 1));
    boundary  = !running || frame_end;

    cnt_nx = (!running || slot_end) ? '0 : slot_cnt + 1'b1;
    if (boundary)
      idx_nx = '0;
    else if (slot_end)
      idx_nx = digit_idx + 1'b1;
    else
      idx_nx = digit_idx;

    if (cnt_nx == '0)
      state_nx = BLANK;
    else if (cnt_nx == CW'(BLANK_CYCLES))
      state_nx = SHOW;
    else
      state_nx = state;

    if (boundary && load)
      disp_nx = digits_in;
    else if (boundary && pending)
      disp_nx = pend_data;
    else
      disp_nx = display;

    nib_nx = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (IW'(k) == idx_nx)
        nib_nx = disp_nx[4*k +: 4];

    run_zero  = 1'b1;
    lead_zero = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run_zero     = run_zero && (disp_nx[4*k +: 4] == 4'h0);
      lead_zero[k] = run_zero && (k != 0);
    end
`else
    lead_zero = '0;
`endif
    suppress = blank_mask | lead_zero;

    anode_nx = '1;
    if (state_nx == SHOW)
      for (int k = 0; k < NUM_DIGITS; k++)
        if (IW'(k) == idx_nx && !suppress[k])
          anode_nx[k] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      running     <= 1'b0;
      slot_cnt    <= '0;
      digit_idx   <= '0;
      anode_n     <= '1;
      seg_in      <= 4'h0;
      frame_start <= 1'b0;
      pending     <= 1'b0;
      display     <= '0;
      pend_data   <= '0;
    end else begin
      running     <= 1'b1;
      state       <= state_nx;
      slot_cnt    <= cnt_nx;
      digit_idx   <= idx_nx;
      anode_n     <= anode_nx;
      frame_start <= boundary;
      display     <= disp_nx;
      // Nibble changes only while all digits are dark, so the decoder settles first.
      if (cnt_nx == '0)
        seg_in <= nib_nx;
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pending   <= 1'b1;
        pend_data <= digits_in;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - directed table-driven bench for seven_segment_scanner
module tb_seven_segment_scanner;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam int LZ = 1;
`else
  localparam int LZ = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  seg_in;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;
  logic        frame_start;
  logic        pending;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seven_segment_scanner #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .digits_in(digits_in),
    .blank_mask(blank_mask),
    .seg_in(seg_in),
    .anode_n(anode_n),
    .digit_idx(digit_idx),
    .frame_start(frame_start),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] anode;
    logic [3:0] seg;
    logic [1:0] idx;
    logic       fs;
  } vec_t;

  vec_t tbl[19];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic count_frame(input int base, input int e0, input int e1, input int e2, input int e3, input string name);
    int lows[4];
    int other;
    lows = '{0, 0, 0, 0};
    other = 0;
    for (int i = 0; i < 32; i++) begin
      goto(base + i);
      if (anode_n == ~(4'b0001 << (i / 8)))
        lows[i / 8]++;
      else if (anode_n != 4'hF)
        other++;
    end
    chk({name, " slot0 lows"}, 32'(lows[0]), 32'(e0));
    chk({name, " slot1 lows"}, 32'(lows[1]), 32'(e1));
    chk({name, " slot2 lows"}, 32'(lows[2]), 32'(e2));
    chk({name, " slot3 lows"}, 32'(lows[3]), 32'(e3));
    chk({name, " stray anode"}, 32'(other), 32'd0);
  endtask

  initial begin
    int seen_a, five_bad, pend_bad, zero_bad;

    tbl[0]  = '{32,  4'h0, 4'hF, 4'h4, 2'd0, 1'b1};
    tbl[1]  = '{33,  4'h0, 4'hF, 4'h4, 2'd0, 1'b0};
    tbl[2]  = '{34,  4'h0, 4'hE, 4'h4, 2'd0, 1'b0};
    tbl[3]  = '{39,  4'h0, 4'hE, 4'h4, 2'd0, 1'b0};
    tbl[4]  = '{40,  4'h0, 4'hF, 4'h3, 2'd1, 1'b0};
    tbl[5]  = '{42,  4'h0, 4'hD, 4'h3, 2'd1, 1'b0};
    tbl[6]  = '{48,  4'h0, 4'hF, 4'h2, 2'd2, 1'b0};
    tbl[7]  = '{50,  4'h0, 4'hB, 4'h2, 2'd2, 1'b0};
    tbl[8]  = '{56,  4'h0, 4'hF, 4'h1, 2'd3, 1'b0};
    tbl[9]  = '{58,  4'h0, 4'h7, 4'h1, 2'd3, 1'b0};
    tbl[10] = '{63,  4'h0, 4'h7, 4'h1, 2'd3, 1'b0};
    tbl[11] = '{96,  4'h4, 4'hF, 4'h4, 2'd0, 1'b1};
    tbl[12] = '{98,  4'h4, 4'hE, 4'h4, 2'd0, 1'b0};
    tbl[13] = '{106, 4'h4, 4'hD, 4'h3, 2'd1, 1'b0};
    tbl[14] = '{112, 4'h4, 4'hF, 4'h2, 2'd2, 1'b0};
    tbl[15] = '{114, 4'h4, 4'hF, 4'h2, 2'd2, 1'b0};
    tbl[16] = '{119, 4'h4, 4'hF, 4'h2, 2'd2, 1'b0};
    tbl[17] = '{120, 4'h4, 4'hF, 4'h1, 2'd3, 1'b0};
    tbl[18] = '{122, 4'h4, 4'h7, 4'h1, 2'd3, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst anode_n", 32'(anode_n), 32'hF);
    chk("rst seg_in", 32'(seg_in), 32'h0);
    chk("rst digit_idx", 32'(digit_idx), 32'h0);
    chk("rst frame_start", 32'(frame_start), 32'h0);
    chk("rst pending", 32'(pending), 32'h0);
    rst = 1'b0;
    cyc = -1;
    step();
    chk("cyc0 frame_start", 32'(frame_start), 32'h1);
    chk("cyc0 anode_n", 32'(anode_n), 32'hF);

    // Load 1234 during frame 0
    goto(5);
    chk("pre-load pending", 32'(pending), 32'h0);
    load = 1'b1; digits_in = 16'h1234;
    step();
    load = 1'b0;
    chk("load pending rise", 32'(pending), 32'h1);
    goto(31);
    chk("pending held", 32'(pending), 32'h1);

    for (int i = 0; i < 11; i++) begin
      goto(tbl[i].cyc - 1);
      blank_mask = tbl[i].mask;
      step();
      chk($sformatf("tbl%0d anode_n", i), 32'(anode_n), 32'(tbl[i].anode));
      chk($sformatf("tbl%0d seg_in", i), 32'(seg_in), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d digit_idx", i), 32'(digit_idx), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
      if (i == 0) chk("pending cleared at boundary", 32'(pending), 32'h0);
    end
    count_frame(64, 6, 6, 6, 6, "frame2");

    // blank_mask on digit 2
    for (int i = 11; i < 19; i++) begin
      goto(tbl[i].cyc - 1);
      blank_mask = tbl[i].mask;
      step();
      chk($sformatf("tbl%0d anode_n", i), 32'(anode_n), 32'(tbl[i].anode));
      chk($sformatf("tbl%0d seg_in", i), 32'(seg_in), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d digit_idx", i), 32'(digit_idx), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
    end
    count_frame(128, 6, 6, 0, 6, "masked frame");
    blank_mask = 4'h0;

    // Two loads in one frame: last wins, no A ever shown
    goto(165);
    load = 1'b1; digits_in = 16'hAAAA;
    step();
    load = 1'b0;
    chk("double load pending", 32'(pending), 32'h1);
    goto(170);
    load = 1'b1; digits_in = 16'h5555;
    step();
    load = 1'b0;
    seen_a = 0; five_bad = 0;
    while (cyc < 223) begin
      step();
      if (seg_in == 4'hA) seen_a++;
      if (cyc >= 192 && seg_in != 4'h5) five_bad++;
      if (cyc == 191) chk("pending before boundary", 32'(pending), 32'h1);
      if (cyc == 192) chk("pending after boundary", 32'(pending), 32'h0);
    end
    chk("no A displayed", 32'(seen_a), 32'd0);
    chk("5555 displayed", 32'(five_bad), 32'd0);

    // Load exactly on the boundary edge
    chk("pending before bnd load", 32'(pending), 32'h0);
    load = 1'b1; digits_in = 16'h0F0F;
    step();
    load = 1'b0;
    chk("bnd load frame_start", 32'(frame_start), 32'h1);
    chk("bnd load seg slot0", 32'(seg_in), 32'hF);
    pend_bad = (pending != 1'b0) ? 1 : 0;
    while (cyc < 255) begin
      step();
      if (pending != 1'b0) pend_bad++;
      if (cyc == 232) chk("bnd load seg slot1", 32'(seg_in), 32'h0);
      if (cyc == 240) chk("bnd load seg slot2", 32'(seg_in), 32'hF);
      if (cyc == 248) chk("bnd load seg slot3", 32'(seg_in), 32'h0);
    end
    chk("bnd load pending never", 32'(pend_bad), 32'd0);

    // Reset mid-frame (slot 1 SHOW) with data pending
    goto(260);
    load = 1'b1; digits_in = 16'h9876;
    step();
    load = 1'b0;
    chk("pre-reset pending", 32'(pending), 32'h1);
    goto(269);
    rst = 1'b1;
    step();
    chk("midrst anode_n", 32'(anode_n), 32'hF);
    chk("midrst digit_idx", 32'(digit_idx), 32'h0);
    chk("midrst pending", 32'(pending), 32'h0);
    chk("midrst seg_in", 32'(seg_in), 32'h0);
    rst = 1'b0;
    cyc = -1;
    zero_bad = 0;
    while (cyc < 63) begin
      step();
      if (seg_in != 4'h0 || pending != 1'b0) zero_bad++;
      if (cyc == 0) chk("restart frame_start", 32'(frame_start), 32'h1);
      if (cyc == 2) chk("restart anode slot0", 32'(anode_n), 32'hE);
      if (cyc == 10) chk("restart anode slot1", 32'(anode_n), LZ ? 32'hF : 32'hD);
    end
    chk("post-reset frames zero", 32'(zero_bad), 32'd0);

    // Leading-zero behaviour (or plain zeros in the default build)
    goto(70);
    load = 1'b1; digits_in = 16'h0040;
    step();
    load = 1'b0;
    count_frame(96, 6, 6, LZ ? 0 : 6, LZ ? 0 : 6, "0040 frame");
    goto(128);
    chk("0040 seg slot0", 32'(seg_in), 32'h0);
    goto(130);
    load = 1'b1; digits_in = 16'h0000;
    step();
    load = 1'b0;
    goto(138);
    chk("0040 seg slot1", 32'(seg_in), 32'h4);
    count_frame(160, 6, LZ ? 0 : 6, LZ ? 0 : 6, LZ ? 0 : 6, "0000 frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed scan controller that shares one `SevenSegmentDecoder` among `NUM_DIGITS` common-anode digits. It holds a frame of BCD/hex nibbles, steps through them at a programmable refresh rate, and drives the shared decoder's 4-bit input and the active-low digit enables. A blanking gap between digits prevents ghosting, and new display data is applied only at frame boundaries, so a frame is never torn.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (2..8).
- `REFRESH_DIV`, 1000: clock cycles per digit slot (≥ `BLANK_CYCLES`+1).
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all digits off (≥1).
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: one-cycle strobe; captures `digits_in`.
- `digits_in` input 4*NUM_DIGITS: nibble k at bits [4k+3:4k]; digit 0 is rightmost.
- `blank_mask` input NUM_DIGITS: bit k=1 forces digit k off. Sampled live, not frame-synchronised.
- `seg_in` output 4: nibble for the shared decoder's input.
- `anode_n` output NUM_DIGITS: active-low digit enables, at most one low.
- `digit_idx` output clog2(NUM_DIGITS): index of the current slot.
- `frame_start` output 1: one-cycle pulse in the first cycle of slot 0.
- `pending` output 1: load captured, not yet displayed.

## Operation
- All outputs registered.
- Reset values:
  - state=BLANK, slot counter=0, `digit_idx`=0.
  - `anode_n`=all 1, `seg_in`=0, `frame_start`=0, `pending`=0.
  - Display and pending registers cleared to 0.
- The FSM has two states.
  - BLANK: `anode_n` all 1. Lasts `BLANK_CYCLES` cycles.
  - SHOW: `anode_n[digit_idx]`=0 unless suppressed. Lasts `REFRESH_DIV`−`BLANK_CYCLES` cycles.
  - SHOW→BLANK advances `digit_idx` by 1 and wraps NUM_DIGITS−1→0.
- `seg_in` is the display nibble of `digit_idx`. It is updated on entry to BLANK so the decoder settles before enable.
- Load path:
  - `load`=1 copies `digits_in` to the pending register and sets `pending`.
  - A load while `pending`=1 overwrites the pending register (last wins).
- Frame boundary is the cycle `digit_idx` wraps to 0. At the boundary, if `pending` is set, display ← pending register and `pending` clears.
  - If `load` coincides with the boundary, `digits_in` goes straight to display and `pending` stays 0.
- Suppression: the digit is held off (`anode_n` bit stays 1) while timing continues unchanged. A digit is suppressed if its `blank_mask` bit is 1.
- `rst` mid-frame: abandons the slot and returns to the reset values on the next edge. Any pending data is lost.

## Timing
- Cycle 0 is the first edge with `rst`=0.
- First frame:
  - Slot 0 is BLANK for cycles 0..`BLANK_CYCLES`−1, then SHOW until cycle `REFRESH_DIV`−1.
  - Slot k starts at cycle k·`REFRESH_DIV`.
  - Frame period is `NUM_DIGITS`·`REFRESH_DIV` cycles.
- `frame_start`: high at cycle 0 and at every multiple of the frame period.
- Load latency:
  - `pending` rises 1 cycle after `load`.
  - New data is visible from the next frame's slot 0, at most one frame period + 1 cycle later.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN`:
  - Defined: additionally suppress every digit whose nibble is 0 and whose higher-index digits are all 0. Digit 0 is never suppressed by this rule.
  - Undefined: only `blank_mask` suppresses digits, and zeros are displayed.

## Test plan
Parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then `load` with `digits_in`=16'h1234 during frame 0:
  - From frame 1: `anode_n` cycles 1110→1101→1011→0111, 6 cycles low each.
  - `seg_in` shows 4,3,2,1.
  - `frame_start` pulses every 32 cycles.
- Two loads in one frame (16'hAAAA then 16'h5555): `pending`=1 until the boundary, and the display shows 5555 with no A visible.
- `load` exactly on the boundary cycle with 16'h0F0F: the display becomes 0F0F in that frame's slot 0, and `pending` never rises.
- `blank_mask`=4'b0100 with display 16'h1234: slot 2 keeps `anode_n`=1111 throughout, and the other slots are unchanged.
- Assert `rst` at cycle 13 (slot 1 SHOW) with `pending`=1:
  - Next cycle: `anode_n`=1111, `digit_idx`=0, `pending`=0.
  - The next displayed frame is 0000.
- With `SEG_LEADING_ZERO_BLANK_EN`, display 16'h0040: digits 3 and 2 are off, digits 1 and 0 show 4 and 0. Display 16'h0000 shows only digit 0.
